// File: rtl/nn_pkg.sv
// Shared types and helpers for the neural-network datapath blocks.
package nn_pkg;

    typedef enum logic [1:0] {
        ACT_IDENT = 2'd0,
        ACT_RELU  = 2'd1,
        ACT_HSIG  = 2'd2,
        ACT_RSVD  = 2'd3
    } act_mode_t;

    // Hard-sigmoid on a sign-extended operand: (x >>> 2) + 0.5, clamped to [0, 1.0].
    // 32 bits of headroom covers every legal DEPTH, so the sum can never wrap.
    function automatic logic [31:0] hsig_clamp(input logic signed [31:0] x,
                                               input int unsigned frac);
        logic signed [31:0] t;
        logic signed [31:0] hi;
        hi = 32'sd1 <<< frac;
        t  = (x >>> 2) + (32'sd1 <<< (frac - 1));
        if (t < 0) begin
            return '0;
        end else if (t > hi) begin
            return hi;
        end
        return t;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with extra-MSB pointers; pop on empty and push on
// full (without a simultaneous pop) are ignored.
module sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign count = wr_ptr_q - rd_ptr_q;

    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push while full still lands.
    assign do_push = push && (!full || do_pop);

    assign pop_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d                = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/neuron_activation.sv
// Post-accumulation stage: capture the final accumulator, apply the selected
// activation and queue the result for the layer output collector.
module neuron_activation
    import nn_pkg::*;
#(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned FRAC       = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DEPTH-1:0]              acc_in,
    input  logic                          acc_done,
    input  logic [1:0]                    act_mode,
    output logic [DEPTH-1:0]              out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    input  logic                          clr_ovf
);

    if (FRAC < 1 || FRAC > DEPTH - 2) begin : g_bad_frac
        $error("neuron_activation: FRAC must lie in [1, DEPTH-2]");
    end

    logic [DEPTH-1:0] s1_data_q, s1_data_d;
    act_mode_t        s1_mode_q, s1_mode_d;
    logic             s1_valid_q, s1_valid_d;
    logic             ovf_q, ovf_d;

    logic [DEPTH-1:0] act_y;
    logic [31:0]      x_ext;
    logic             fifo_full, fifo_empty, pop, drop;

    always_comb begin
        s1_valid_d = acc_done;
        s1_data_d  = s1_data_q;
        s1_mode_d  = s1_mode_q;
        if (acc_done) begin
            s1_data_d = acc_in;
            s1_mode_d = act_mode_t'(act_mode);
        end
    end

    assign x_ext = {{(32 - DEPTH){s1_data_q[DEPTH-1]}}, s1_data_q};

    always_comb begin
        act_y = s1_data_q;
        case (s1_mode_q)
            ACT_RELU: if (s1_data_q[DEPTH-1]) act_y = '0;
            ACT_HSIG: act_y = DEPTH'(hsig_clamp(x_ext, FRAC));
            default:  act_y = s1_data_q;
        endcase
    end

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign drop      = s1_valid_q && fifo_full && !pop;

    // Set beats clear so a drop in the clearing cycle is never lost.
    always_comb begin
        ovf_d = ovf_q;
        if (clr_ovf) ovf_d = 1'b0;
        if (drop)    ovf_d = 1'b1;
    end
    assign overflow = ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_mode_q  <= ACT_IDENT;
            ovf_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_mode_q  <= s1_mode_d;
            ovf_q      <= ovf_d;
        end
    end

    sync_fifo #(
        .WIDTH (DEPTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (s1_valid_q),
        .push_data (act_y),
        .pop       (pop),
        .pop_data  (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (count)
    );

endmodule

// File: tb/tb_neuron_activation.sv
// Directed bench for neuron_activation with hand-computed expected values.
module tb_neuron_activation;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] acc_in = '0;
    logic        acc_done = 1'b0;
    logic [1:0]  act_mode = '0;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [2:0]  count;
    logic        overflow;
    logic        clr_ovf = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    neuron_activation #(
        .DEPTH      (16),
        .FRAC       (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .acc_in    (acc_in),
        .acc_done  (acc_done),
        .act_mode  (act_mode),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] v, input logic [1:0] m);
        acc_in   = v;
        act_mode = m;
        acc_done = 1'b1;
        tick();
        acc_done = 1'b0;
    endtask

    logic [15:0] vec_in   [8];
    logic [1:0]  vec_mode [8];
    logic [15:0] vec_exp  [8];
    logic [15:0] stream   [12];

    initial begin
        vec_in[0] = 16'hFF00; vec_mode[0] = 2'd1; vec_exp[0] = 16'h0000;
        vec_in[1] = 16'h0180; vec_mode[1] = 2'd1; vec_exp[1] = 16'h0180;
        vec_in[2] = 16'h0000; vec_mode[2] = 2'd2; vec_exp[2] = 16'h0080;
        vec_in[3] = 16'h0200; vec_mode[3] = 2'd2; vec_exp[3] = 16'h0100;
        vec_in[4] = 16'h7FFF; vec_mode[4] = 2'd2; vec_exp[4] = 16'h0100;
        vec_in[5] = 16'hFE00; vec_mode[5] = 2'd2; vec_exp[5] = 16'h0000;
        vec_in[6] = 16'h8000; vec_mode[6] = 2'd2; vec_exp[6] = 16'h0000;
        vec_in[7] = 16'hFF00; vec_mode[7] = 2'd2; vec_exp[7] = 16'h0040;

        // Reset
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);

        // Activation points, with 2-cycle latency on each
        for (int i = 0; i < 8; i++) begin
            send(vec_in[i], vec_mode[i]);
            check($sformatf("lat1_%0d", i), 32'(out_valid), 32'd0);
            tick();
            check($sformatf("lat2_%0d", i), 32'(out_valid), 32'd1);
            check($sformatf("act_%0d", i), 32'(out_data), 32'(vec_exp[i]));
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check($sformatf("drain_%0d", i), 32'(count), 32'd0);
        end

        // Reserved mode behaves as identity
        send(16'hFF00, 2'd3);
        tick();
        check("rsvd", 32'(out_data), 32'hFF00);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Fill and overflow
        for (int i = 1; i <= 5; i++) send(16'(i), 2'd0);
        tick();
        check("fill_count", 32'(count), 32'd4);
        check("fill_ovf", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("fill_pop_%0d", i), 32'(out_data), 32'(i));
            tick();
        end
        out_ready = 1'b0;
        check("fill_empty", 32'(out_valid), 32'd0);
        check("fill_cnt0", 32'(count), 32'd0);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("ovf_clr", 32'(overflow), 32'd0);

        // Full push+pop across pointer wrap
        for (int i = 0; i < 4; i++) stream[i] = 16'(10 + i);
        for (int i = 4; i < 12; i++) stream[i] = 16'(16 + i);
        for (int i = 0; i < 17; i++) begin
            if (i < 12) begin
                acc_in   = stream[i];
                act_mode = 2'd0;
                acc_done = 1'b1;
            end else begin
                acc_done = 1'b0;
            end
            out_ready = (i >= 5);
            if (i >= 5 && i <= 12) check($sformatf("pp_count_%0d", i), 32'(count), 32'd4);
            if (i >= 5) begin
                check($sformatf("pp_valid_%0d", i), 32'(out_valid), 32'd1);
                check($sformatf("pp_data_%0d", i), 32'(out_data), 32'(stream[i-5]));
            end
            tick();
        end
        acc_done  = 1'b0;
        out_ready = 1'b0;
        check("pp_ovf", 32'(overflow), 32'd0);
        check("pp_end_count", 32'(count), 32'd0);

        // Clear and set in the same cycle: set wins
        for (int i = 0; i < 4; i++) send(16'(i), 2'd0);
        tick();
        check("cs_count", 32'(count), 32'd4);
        clr_ovf = 1'b1;
        send(16'h00AA, 2'd0);
        tick();
        clr_ovf = 1'b0;
        check("cs_ovf", 32'(overflow), 32'd1);

        // Reset mid-operation discards queued and in-flight results
        rst = 1'b1;
        tick();
        rst = 1'b0;
        send(16'h0011, 2'd0);
        send(16'h0022, 2'd0);
        tick();
        check("mid_count2", 32'(count), 32'd2);
        send(16'h0055, 2'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_count", 32'(count), 32'd0);
        check("mid_valid", 32'(out_valid), 32'd0);
        check("mid_data", 32'(out_data), 32'd0);
        tick();
        tick();
        check("mid_inflight", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/neuron_activation.md
# neuron_activation

Post-accumulation stage for one neuron lane. Captures the neuron's final saturated dot-product accumulator on a done pulse, applies a selectable fixed-point activation (identity, ReLU, hard-sigmoid), and queues results in a small FIFO. The FIFO exposes a valid/ready interface to the layer output collector. Sits directly downstream of the serial MAC neuron. Its `acc_in` is wired to the neuron's `y`.

## Interface
- `DEPTH`, 16: data width; signed two's complement, same as the neuron's `DEPTH`.
- `FRAC`, 8: number of fractional bits; constraint 1 ≤ FRAC ≤ DEPTH-2 (checked by elaboration assertion).
- `FIFO_DEPTH`, 4: output queue entries; power of two, ≥ 2.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `acc_in` input DEPTH: final neuron accumulator, signed Q(DEPTH-FRAC).FRAC.
- `acc_done` input 1: one-cycle pulse; `acc_in` is valid and final in this cycle.
- `act_mode` input 2: sampled with `acc_done`; 0 = identity, 1 = ReLU, 2 = hard-sigmoid, 3 = reserved (treated as identity).
- `out_data` output DEPTH: head-of-FIFO activation result.
- `out_valid` output 1: FIFO non-empty.
- `out_ready` input 1: consumer accepts `out_data` when `out_valid && out_ready`.
- `count` output $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `overflow` output 1: sticky; a result was dropped because the FIFO was full.
- `clr_ovf` input 1: clears `overflow`.

## Operation
- Stage 1 (capture): on `acc_done`, register `acc_in`, `act_mode` and a stage-valid bit. With no `acc_done`, the stage-valid bit clears. Back-to-back `acc_done` is legal every cycle.
- Stage 2 (activate, combinational from stage 1 registers):
  - Identity: y = x.
  - ReLU: y = x if x ≥ 0, else 0.
  - Hard-sigmoid: t = (x >>> 2) + 2^(FRAC-1), computed in DEPTH+1 bits, then clamped to [0, 2^FRAC]. The arithmetic shift rounds toward −∞.
  - Result is always DEPTH bits; no other rounding or saturation.
- Push: if the stage-1 valid bit is set, the result is written to the FIFO tail on the next edge.
- FIFO: circular buffer with read/write pointers one bit wider than the index. Full when the indexes are equal and the MSBs differ.
- Pop: `out_valid && out_ready` advances the read pointer. `out_data` is the registered head entry; show-ahead, so no extra read latency.
- Boundary cases:
  - Push while full with no pop in the same cycle: the result is dropped, `overflow` sets, and pointers are unchanged.
  - Push and pop in the same cycle while full: both occur; count is unchanged; no overflow.
  - Push and pop in the same cycle while empty: no pop occurs (`out_valid` is low); the push lands.
  - Pointer wrap at FIFO_DEPTH is seamless.
  - `out_ready` while `out_valid` is low: ignored.
  - `clr_ovf` and a new overflow in the same cycle: `overflow` stays 1 (set wins).
- Reset: all outputs and state are reset synchronously.
  - `out_valid` = 0, `count` = 0, `overflow` = 0, `out_data` = 0.
  - Stage-valid bit = 0; pointers = 0.
  - A result in flight in stage 1 is discarded.

## Timing
- `acc_done` sampled at edge E0 → entry written at E1 → `out_valid` high after E1.
- Latency is 2 cycles from the `acc_done` cycle to the first `out_valid` cycle, with the FIFO empty.
- Throughput: one result per cycle sustained while `out_ready` is held high.
- `count` and `overflow` update on the same edge as the push or pop that causes the change.
- `acc_in` is sampled on the rising edge. The neuron updates on the falling edge, so `acc_in` is stable through the sampling edge.
- `rst` takes priority over every other input in the same cycle.

## Structure
- Shared package `nn_pkg`:
  - Enum `act_mode_t` (`ACT_IDENT`, `ACT_RELU`, `ACT_HSIG`, `ACT_RSVD`).
  - Function for the hard-sigmoid clamp, parameterised by DEPTH and FRAC.
- Sub-module `sync_fifo` (params WIDTH, DEPTH), reusable by the layer collector. Owns the pointers, `count`, and the full/empty flags.
- Top level holds stage 1, the activation mux and the overflow flag.

## Test plan
All values below use DEPTH=16, FRAC=8, FIFO_DEPTH=4.
- Reset check: hold `rst` for 2 cycles → `out_valid`=0, `count`=0, `overflow`=0, `out_data`=0.
- ReLU sign handling:
  - `acc_in`=0xFF00 (−1.0), mode 1 → `out_data`=0x0000.
  - `acc_in`=0x0180, mode 1 → `out_data`=0x0180.
  - `out_valid` rises exactly 2 cycles after each `acc_done` pulse.
- Hard-sigmoid points, mode 2:
  - 0x0000 → 0x0080.
  - 0x0200 (+2.0) → 0x0100.
  - 0x7FFF → 0x0100 (clamped).
  - 0xFE00 (−2.0) → 0x0000.
  - 0x8000 → 0x0000.
  - 0xFF00 → 0x0040.
- Fill and overflow, with `out_ready`=0:
  - Send 5 `acc_done` pulses with values 1..5 → `count`=4, `overflow`=1.
  - Then pop all → values read out are 1, 2, 3, 4; value 5 is not present.
- Full push+pop: FIFO full, `out_ready`=1, `acc_done` every cycle for 8 cycles → `count` holds at 4, `overflow` stays 0, output order is preserved across pointer wrap.
- Reset mid-operation: assert `rst` one cycle after `acc_done` with 2 entries queued → next cycle `count`=0, `out_valid`=0, and the in-flight result never appears.
